// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits one bit per clock, with an optional forced idle gap between words.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  PENULT   = CNT_W'(WIDTH - 2);
  localparam logic [3:0]        GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0] r_bitcnt, w_bitcnt_nxt;
  logic [3:0]       r_gapcnt, w_gapcnt_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_dout_valid, w_dout_valid_nxt;
  logic             r_word_done, w_word_done_nxt;

  logic             w_last_bit, w_gap_last, w_accept;
  logic             w_load_bit, w_shift_bit;
  logic [WIDTH-1:0] w_load_rest, w_shift_rest;

  // The shift register holds only the bits not yet presented on dout.
  always_comb begin
    if (MSB_FIRST) begin
      w_load_bit   = din[WIDTH-1];
      w_load_rest  = din << 1;
      w_shift_bit  = r_shreg[WIDTH-1];
      w_shift_rest = r_shreg << 1;
    end else begin
      w_load_bit   = din[0];
      w_load_rest  = din >> 1;
      w_shift_bit  = r_shreg[0];
      w_shift_rest = r_shreg >> 1;
    end
  end

  assign w_last_bit = (r_state == S_SHIFT) && (r_bitcnt == LAST_BIT);
  assign w_gap_last = (GAP > 0) && (r_state == S_GAP) && (r_gapcnt == GAP_LAST);
  assign din_ready  = (r_state == S_IDLE) || (w_last_bit && (GAP == 0)) || w_gap_last;
  assign w_accept   = din_valid && din_ready;
  assign busy       = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_bitcnt_nxt     = r_bitcnt;
    w_gapcnt_nxt     = r_gapcnt;
    w_dout_nxt       = 1'b0;
    w_dout_valid_nxt = 1'b0;
    w_word_done_nxt  = 1'b0;
    if (w_accept) begin
      w_state_nxt      = S_SHIFT;
      w_shreg_nxt      = w_load_rest;
      w_bitcnt_nxt     = '0;
      w_gapcnt_nxt     = '0;
      w_dout_nxt       = w_load_bit;
      w_dout_valid_nxt = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_SHIFT: begin
          if (r_bitcnt == LAST_BIT) begin
            w_gapcnt_nxt = '0;
            w_state_nxt  = (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            w_shreg_nxt      = w_shift_rest;
            w_bitcnt_nxt     = r_bitcnt + 1'b1;
            w_dout_nxt       = w_shift_bit;
            w_dout_valid_nxt = 1'b1;
            w_word_done_nxt  = (r_bitcnt == PENULT);
          end
        end
        S_GAP: begin
          if (r_gapcnt == GAP_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_gapcnt_nxt = r_gapcnt + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_gapcnt     <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_word_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_gapcnt     <= w_gapcnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_word_done  <= w_word_done_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign word_done  = r_word_done;

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the single-bit Mealy ones-counting FSM. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `dout`, which drives the FSM's `in` directly. Idle and gap cycles drive `dout` low, so they never advance the downstream counter. An optional inter-word gap and a per-word completion pulse support framing.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- GAP, 0, idle cycles forced between consecutive words; legal range 0..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- din  input  WIDTH  parallel word; sampled only on an accepting edge.
- din_valid  input  1  upstream has a word on `din`.
- din_ready  output  1  block can accept a word this cycle (combinational from state).
- dout  output  1  serial bit, registered; 0 whenever `dout_valid` = 0.
- dout_valid  output  1  `dout` carries a data bit this cycle, registered.
- word_done  output  1  registered; high during the cycle the last bit of a word is on `dout`.
- busy  output  1  high in SHIFT or GAP.

## Operation
- States: IDLE, SHIFT, GAP. Internal registers: shift register (WIDTH), bit counter (ceil(log2(WIDTH)) bits), gap counter (4 bits).
- Accept: a word is accepted on a rising edge when `din_valid` && `din_ready`.
- `din_ready` is high in any of these cases:
  - in IDLE;
  - in SHIFT on the last bit (bit counter = WIDTH-1) when GAP = 0;
  - in GAP on its final cycle (gap counter = GAP-1).
- IDLE:
  - on accept, load the shift register, drive the first bit onto `dout`, set `dout_valid` = 1, clear the bit counter and go to SHIFT;
  - otherwise `dout` = 0 and `dout_valid` = 0.
- SHIFT:
  - each edge presents the next bit (MSB_FIRST selects the direction) and increments the bit counter;
  - `word_done` = 1 while the bit counter = WIDTH-1.
- Edge leaving the last bit:
  - GAP = 0 and accept: load the new word, present its first bit and stay in SHIFT (no bubble);
  - GAP = 0, no accept: go to IDLE;
  - GAP > 0: go to GAP with the gap counter cleared, `dout` = 0, `dout_valid` = 0.
- GAP:
  - the gap counter increments each cycle;
  - on the final gap cycle, accept loads a word and goes to SHIFT; otherwise go to IDLE.
- `din` and `din_valid` are ignored in every cycle where `din_ready` = 0. A dropped `din_valid` without an accept leaves no residue.
- Reset (async, any state):
  - state = IDLE, counters = 0, shift register = 0;
  - `dout` = 0, `dout_valid` = 0, `word_done` = 0, `busy` = 0, so `din_ready` = 1;
  - any word in flight is discarded; there is no resume after deassertion.

## Timing
- Latency: a word accepted at edge k has its first bit on `dout` from edge k through edge k+1. Bit i appears in cycle k+i, for i = 0..WIDTH-1.
- Throughput with GAP = 0: one bit per clock sustained; back-to-back words produce a contiguous `dout_valid`.
- Throughput with GAP = g: WIDTH valid cycles, then g cycles with `dout_valid` = 0. The next word's first bit appears at the earliest on the edge after the final gap cycle.
- `word_done` is high for exactly 1 cycle per word, coincident with the last bit.
- Reset deassertion: the first accept can occur on the first rising edge after `reset_n` rises.

## Test plan
- Reset values: hold `reset_n` = 0 for 3 cycles -> `dout` = 0, `dout_valid` = 0, `word_done` = 0, `busy` = 0, `din_ready` = 1.
- Single word, WIDTH = 8, MSB_FIRST = 1, `din` = 8'hA5 -> `dout` = 1,0,1,0,0,1,0,1 over 8 consecutive valid cycles; `word_done` high only on the 8th; then IDLE with `dout` = 0. A downstream ones-counter sees 4 ones and wraps to its start state.
- LSB first, MSB_FIRST = 0, `din` = 8'h01 -> `dout` = 1 followed by seven 0s.
- Back-to-back, GAP = 0, `din_valid` held high with 8'hFF then 8'h00 -> 16 contiguous `dout_valid` cycles (eight 1s, then eight 0s); `din_ready` high only in IDLE and on each last-bit cycle.
- Gap, GAP = 2, two words with `din_valid` held high -> exactly 2 cycles of `dout_valid` = 0 between words; `din_ready` low on the first gap cycle and high on the second.
- Reset mid-word: assert `reset_n` low during bit 3 of 8'hA5 -> outputs go to reset values immediately, without waiting for a clock edge; after release, a new word 8'h80 serializes cleanly as 1 followed by seven 0s.
